neuron_mac_scheduler: RTL and testbench

// - Sequences the shared 16-accumulator pipelined MAC array through a full layer evaluation.
// - Evaluates NUM_NEURONS neurons one after another. Each neuron runs BATCH_SIZE feed steps, a pipeline drain and a reduce/bias capture.
// - Presents each neuron result slot with a valid/ready handshake, then pulses done once per layer.
// - Sits between the top-level classifier control and the Neuron datapath. It drives the pixel/weight step index and neuron select to the operand muxes.

---
 rtl/neuron_mac_scheduler.sv | 164 ++++++++++++++++
 tb/tb_neuron_mac_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_scheduler.sv
// Layer sequencer for the shared pipelined MAC array: per neuron it runs clear, feed,
// drain, reduce and a valid/ready result slot, then pulses done once per layer.
module neuron_mac_scheduler #(
    parameter int unsigned NUM_NEURONS         = 10,
    parameter int unsigned BATCH_SIZE          = 49,
    parameter int unsigned NUM_OF_ACCUMULATORS = 16,
    parameter int unsigned PIPE_DEPTH          = 2,
    parameter int unsigned IDX_WIDTH           = 6,
    parameter int unsigned SEL_WIDTH           = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 acc_clr,
    output logic                 acc_en,
    output logic [IDX_WIDTH-1:0] step_idx,
    output logic [SEL_WIDTH-1:0] neuron_sel,
    output logic                 reduce_en,
    output logic                 out_valid,
    output logic                 done
);

    localparam int unsigned DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    // Elaboration-time sanity check on the parameter set.
    if (PIPE_DEPTH < 1 || (2 ** IDX_WIDTH) < BATCH_SIZE || (2 ** SEL_WIDTH) < NUM_NEURONS ||
        NUM_OF_ACCUMULATORS == 0) begin : g_bad_params
        $error("neuron_mac_scheduler: inconsistent parameters");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_REDUCE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] step_q, step_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 busy_q, busy_d;
    logic                 clr_q, clr_d;
    logic                 en_q, en_d;
    logic                 red_q, red_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;

    // Next-state and counter update; output flags are decoded from the next state so
    // every output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        sel_d   = sel_q;
        drain_d = drain_q;
        if (abort) begin
            state_d = S_IDLE;
            step_d  = '0;
            sel_d   = '0;
            drain_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CLEAR;
                        sel_d   = '0;
                        step_d  = '0;
                    end
                end
                S_CLEAR: begin
                    state_d = S_FEED;
                    step_d  = '0;
                end
                S_FEED: begin
                    if (step_q == IDX_WIDTH'(BATCH_SIZE - 1)) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        step_d = step_q + IDX_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_W'(PIPE_DEPTH - 1)) begin
                        state_d = S_REDUCE;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + DRAIN_W'(1);
                    end
                end
                S_REDUCE: state_d = S_OUTPUT;
                S_OUTPUT: begin
                    if (out_ready) begin
                        if (sel_q == SEL_WIDTH'(NUM_NEURONS - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CLEAR;
                            sel_d   = sel_q + SEL_WIDTH'(1);
                            step_d  = '0;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                    step_d  = '0;
                end
                default: begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    sel_d   = '0;
                    drain_d = '0;
                end
            endcase
        end
        busy_d  = (state_d != S_IDLE);
        clr_d   = (state_d == S_CLEAR);
        en_d    = (state_d == S_FEED);
        red_d   = (state_d == S_REDUCE);
        valid_d = (state_d == S_OUTPUT);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            sel_q   <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            red_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            sel_q   <= sel_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            red_q   <= red_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign acc_clr    = clr_q;
    assign acc_en     = en_q;
    assign step_idx   = step_q;
    assign neuron_sel = sel_q;
    assign reduce_en  = red_q;
    assign out_valid  = valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_neuron_mac_scheduler.sv
// Self-checking bench for neuron_mac_scheduler: a per-neuron cycle-offset reference
// model is compared against every output on every cycle, plus directed latency checks.
module tb_neuron_mac_scheduler;

    localparam int N     = 10;
    localparam int B     = 49;
    localparam int PD    = 2;
    localparam int IW    = 6;
    localparam int SW    = 4;
    localparam int OUT_T = B + PD + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, out_ready;
    logic          busy, acc_clr, acc_en, reduce_en, out_valid, done;
    logic [IW-1:0] step_idx;
    logic [SW-1:0] neuron_sel;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;
    int start_edge = 0;
    int done_seen  = 0;
    int last_lat   = 0;

    // Reference model: mode 0 idle, 1 running neuron m_n at offset m_t, 2 done cycle.
    int m_mode = 0;
    int m_n    = 0;
    int m_t    = 0;

    neuron_mac_scheduler #(
        .NUM_NEURONS(N), .BATCH_SIZE(B), .NUM_OF_ACCUMULATORS(16),
        .PIPE_DEPTH(PD), .IDX_WIDTH(IW), .SEL_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .out_ready(out_ready),
        .busy(busy), .acc_clr(acc_clr), .acc_en(acc_en), .step_idx(step_idx),
        .neuron_sel(neuron_sel), .reduce_en(reduce_en), .out_valid(out_valid), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] expected_outputs();
        logic b, c, e, r, v, d;
        int   st, sl;
        b = 0; c = 0; e = 0; r = 0; v = 0; d = 0; st = 0; sl = 0;
        if (m_mode == 2) begin
            b = 1; d = 1; st = B - 1; sl = N - 1;
        end else if (m_mode == 1) begin
            b  = 1;
            sl = m_n;
            if (m_t == 0) c = 1;
            else if (m_t <= B) begin e = 1; st = m_t - 1; end
            else begin
                st = B - 1;
                r  = (m_t == B + PD + 1);
                v  = (m_t >= OUT_T);
            end
        end
        return {b, c, e, r, v, d, IW'(st), SW'(sl)};
    endfunction

    function automatic logic [15:0] observed();
        return {busy, acc_clr, acc_en, reduce_en, out_valid, done, step_idx, neuron_sel};
    endfunction

    task automatic check_outputs();
        logic [15:0] exp_v, got_v;
        exp_v = expected_outputs();
        got_v = observed();
        checks++;
        assert (got_v === exp_v) else begin
            failures++;
            $error("FAIL outputs cycle=%0d observed=%h expected=%h", edges, got_v, exp_v);
        end
        checks++;
        assert ($onehot0({acc_clr, acc_en, reduce_en, out_valid}) === 1'b1) else begin
            failures++;
            $error("FAIL exclusive cycle=%0d observed=%b expected=onehot0",
                   edges, {acc_clr, acc_en, reduce_en, out_valid});
        end
        if (done === 1'b1) begin
            done_seen++;
            last_lat = edges - start_edge;
        end
    endtask

    task automatic model_update(input logic s, input logic a, input logic r);
        if (a) m_mode = 0;
        else if (m_mode == 0) begin
            if (s) begin m_mode = 1; m_n = 0; m_t = 0; start_edge = edges; end
        end else if (m_mode == 2) m_mode = 0;
        else if (m_t < OUT_T) m_t++;
        else if (r) begin
            if (m_n == N - 1) m_mode = 2;
            else begin m_n++; m_t = 0; end
        end
    endtask

    task automatic step_cycle(input logic s, input logic a, input logic r);
        @(negedge clk);
        check_outputs();
        start     = s;
        abort     = a;
        out_ready = r;
        model_update(s, a, r);
        @(posedge clk);
        edges++;
    endtask

    // policy: 0 ready high, 1 random ready + stray starts, 2 backpressure on neuron 3,
    // 3 abort at neuron 2 step 30, 4 start pulse during neuron 5 feed.
    task automatic run_layer(input int policy, input int exp_dones, input int exp_lat);
        int  hold;
        logic s, a, r;
        hold      = 0;
        done_seen = 0;
        step_cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4000 && m_mode != 0; i++) begin
            s = 1'b0; a = 1'b0; r = 1'b1;
            case (policy)
                1: begin
                    r = ($urandom_range(3, 0) != 0);
                    s = ($urandom_range(7, 0) == 0);
                end
                2: if (m_mode == 1 && m_n == 3 && m_t == OUT_T) begin
                    r = (hold >= 20);
                    hold++;
                end
                3: a = (m_mode == 1 && m_n == 2 && m_t == 31);
                4: s = (m_mode == 1 && m_n == 5 && m_t == 10);
                default: ;
            endcase
            step_cycle(s, a, r);
        end
        checks++;
        assert (m_mode === 0) else begin
            failures++;
            $error("FAIL timeout policy=%0d observed_mode=%0d expected=0", policy, m_mode);
        end
        step_cycle(1'b0, 1'b0, 1'b1);
        checks++;
        assert (busy === 1'b0) else begin
            failures++;
            $error("FAIL idle_after policy=%0d observed=%b expected=0", policy, busy);
        end
        checks++;
        assert (done_seen === exp_dones) else begin
            failures++;
            $error("FAIL done_count policy=%0d observed=%0d expected=%0d", policy, done_seen, exp_dones);
        end
        if (exp_lat > 0) begin
            checks++;
            assert (last_lat === exp_lat) else begin
                failures++;
                $error("FAIL done_cycle policy=%0d observed=%0d expected=%0d", policy, last_lat, exp_lat);
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #12;
        checks++;
        assert (observed() === 16'h0) else begin
            failures++;
            $error("FAIL reset_state observed=%h expected=0000", observed());
        end
        @(negedge clk);
        rst = 1'b1;

        run_layer(0, 1, 541);
        run_layer(2, 1, 561);
        run_layer(4, 1, 541);
        run_layer(3, 0, 0);
        run_layer(0, 1, 541);
        for (int k = 0; k < 3; k++) run_layer(1, 1, 0);

        // Async reset dropped between edges while draining.
        step_cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 200 && !(m_mode == 1 && m_t == B + 1); i++)
            step_cycle(1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        assert (observed() === 16'h0) else begin
            failures++;
            $error("FAIL async_reset observed=%h expected=0000", observed());
        end
        m_mode = 0;
        start = 1'bx; abort = 1'bx; out_ready = 1'bx;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;

        step_cycle(1'b1, 1'b1, 1'b1);
        step_cycle(1'b0, 1'b0, 1'b1);
        checks++;
        assert (busy === 1'b0) else begin
            failures++;
            $error("FAIL start_abort observed=%b expected=0", busy);
        end
        run_layer(0, 1, 541);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
